ahb_mailbox_reader: RTL and testbench
=====================================

AHB_MAILBOX_READER -- requirements
Module: ahb_mailbox_reader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AHB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, AHB data width and message word width.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0000_0000, mailbox base; control word at BASE_ADDR+0x0000, payload RAM at BASE_ADDR+0x8000.
REQ-004 SHALL have ports:
- hclk  in  1  clock.
- hresetn  in  1  reset, asynchronous, active-low.
- enable  in  1  service enable.
- mailbox_intr  in  1  mailbox interrupt.
- haddr  out  ADDR_WIDTH  AHB address.
- htrans  out  2  IDLE or NONSEQ only.
- hwrite  out  1  write strobe.
- hsize  out  3  constant 3'b010 (word).
- hburst  out  3  constant SINGLE.
- hprot  out  4  constant 4'b0011.
- hwdata  out  DATA_WIDTH  write data.
- hrdata  in  DATA_WIDTH  read data.
- hready  in  1  transfer done.
- hresp  in  2  OKAY/ERROR.
- msg_valid  out  1  payload word valid.
- msg_ready  in  1  sink accepts word.
- msg_data  out  DATA_WIDTH  payload word.
- msg_last  out  1  final payload word.
- msg_id  out  8  message id, stable for the whole message.
- err  out  1  one-cycle error pulse.

Function
REQ-005 SHALL issue at most one outstanding AHB transfer: NONSEQ for a single cycle with hready high, then IDLE during the data phase.
REQ-006 SHALL hold haddr, hwrite and htrans stable while the address phase sees hready low.
REQ-007 SHALL use FSM states IDLE, CTRL_A, CTRL_D, DATA_A, DATA_D, PUSH, ACK_A, ACK_D, DONE.
REQ-008 IDLE -> CTRL_A when enable=1 and mailbox_intr=1; otherwise remain in IDLE.
REQ-009 CTRL_A issues a read of BASE_ADDR; CTRL_D, on hready=1, latches the control word: id=[7:0], size=[22:8] (payload words).
REQ-010 After CTRL_D: size=0 -> ACK_A; size>8192 -> err pulse, then ACK_A; otherwise DATA_A with word index=0.
REQ-011 DATA_A issues a read of BASE_ADDR+0x8000+4*index; DATA_D, on hready=1, registers hrdata into msg_data and enters PUSH.
REQ-012 PUSH asserts msg_valid with msg_last=(index==size-1); on msg_ready=1, index increments, then the FSM goes to DATA_A, or to ACK_A after the last word.
REQ-013 msg_data, msg_last and msg_id SHALL stay stable while msg_valid=1 and msg_ready=0; msg_valid is never asserted outside PUSH.
REQ-014 ACK_A issues a write to BASE_ADDR; ACK_D drives hwdata={intr=0, flag=1, rsvd=0, size, id} and completes on hready=1.
REQ-015 DONE -> IDLE once mailbox_intr=0; this prevents re-servicing the same message.
REQ-016 hresp=ERROR in CTRL_D or DATA_D: one-cycle err pulse, no msg_valid for that word, go to ACK_A.
REQ-017 hresp=ERROR in ACK_D: err pulse, go to DONE.
REQ-018 Deassertion of enable mid-message SHALL NOT abort the message; it is sampled only in IDLE.
REQ-019 The index counter SHALL be 14 bits wide; the payload address is formed from the index and never wraps beyond 0x7FFC.

Reset
REQ-020 On hresetn=0, asynchronously: FSM=IDLE, htrans=IDLE, haddr=0, hwrite=0, hwdata=0, msg_valid=0, msg_last=0, msg_data=0, msg_id=0, err=0, index=0.
REQ-021 Reset mid-transfer SHALL abandon the message; after reset release a still-high mailbox_intr is serviced from CTRL_A.

Structure
REQ-022 The AHB htrans/hresp/hburst encodings and a packed mailbox control-word typedef (intr, flag, rsvd[29:23], size[22:8], id[7:0]) SHALL live in the shared ahb_enum package.
REQ-023 SHALL be a single module with no sub-modules.

Verification
REQ-024 Control word 0x8000_0305 with 3 payload words, msg_ready always 1 -> 3 msg_valid beats, msg_id=0x05, msg_last on beat 3, then a write of 0x4000_0305 to BASE_ADDR.
REQ-025 Same message with msg_ready low for 5 cycles on beat 2 -> msg_data held constant throughout, no AHB transfer issued during the stall.
REQ-026 Control word size=0 -> no payload reads, ack written immediately, no msg_valid.
REQ-027 hready held low for 4 cycles in CTRL_A and in DATA_D -> address/control held stable, captured data correct.
REQ-028 hresp=ERROR on payload word 2 of 4 -> err pulse, 1 word delivered, ack written, return to IDLE after mailbox_intr falls.
REQ-029 Reset asserted during DATA_D -> all outputs at their reset values, the message re-serviced from CTRL_A after release.

Source files
------------

// File: rtl/ahb_enum.sv
// Shared AHB encodings and mailbox word layout for the mailbox reader.
//   htrans_t    : AHB transfer type encoding
//   hresp_t     : AHB response encoding
//   hburst_t    : AHB burst encoding
//   mbox_ctrl_t : mailbox control word {intr, flag, rsvd, size, id}
//   mbx_state_t : mailbox reader FSM state encoding
package ahb_enum;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } hresp_t;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_t;

    typedef struct packed {
        logic        intr;
        logic        flag;
        logic [6:0]  rsvd;
        logic [14:0] size;
        logic [7:0]  id;
    } mbox_ctrl_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CTRL_A,
        ST_CTRL_D,
        ST_DATA_A,
        ST_DATA_D,
        ST_PUSH,
        ST_ACK_A,
        ST_ACK_D,
        ST_DONE
    } mbx_state_t;

    localparam logic [2:0]  HSIZE_WORD     = 3'b010;
    localparam logic [3:0]  HPROT_DEFAULT  = 4'b0011;
    localparam logic [31:0] PAYLOAD_OFFSET = 32'h0000_8000;
    localparam logic [14:0] MAX_MSG_WORDS  = 15'd8192;

    // Acknowledge word written back once a message has been consumed:
    // interrupt cleared, flag set, size/id echoed from the control word.
    function automatic mbox_ctrl_t ack_word(input logic [14:0] size,
                                            input logic [7:0]  id);
        mbox_ctrl_t w;
        w.intr = 1'b0;
        w.flag = 1'b1;
        w.rsvd = '0;
        w.size = size;
        w.id   = id;
        return w;
    endfunction

endpackage

// File: rtl/ahb_mailbox_reader.sv
// AHB mailbox reader. On a mailbox interrupt (with enable set) it reads the
// control word, streams the payload words out over a valid/ready port, then
// writes an acknowledge word back to the control location.
//   hclk, hresetn                 : clock, async active-low reset
//   enable, mailbox_intr          : service enable, mailbox interrupt
//   haddr..hwdata, hrdata/hready/hresp : AHB-Lite master, single transfers
//   msg_valid/ready/data/last/id  : payload stream to the sink
//   err                           : one-cycle error pulse
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for enable & mailbox_intr
// CTRL_A  | address phase, read of control word
// CTRL_D  | data phase, latch id/size and decide the path
// DATA_A  | address phase, read of payload word [index]
// DATA_D  | data phase, capture payload word
// PUSH    | offer payload word to the sink
// ACK_A   | address phase, write of acknowledge word
// ACK_D   | data phase, acknowledge word on hwdata
// DONE    | wait for mailbox_intr to drop
module ahb_mailbox_reader
    import ahb_enum::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic                  enable,
    input  logic                  mailbox_intr,
    output logic [ADDR_WIDTH-1:0] haddr,
    output logic [1:0]            htrans,
    output logic                  hwrite,
    output logic [2:0]            hsize,
    output logic [2:0]            hburst,
    output logic [3:0]            hprot,
    output logic [DATA_WIDTH-1:0] hwdata,
    input  logic [DATA_WIDTH-1:0] hrdata,
    input  logic                  hready,
    input  logic [1:0]            hresp,
    output logic                  msg_valid,
    input  logic                  msg_ready,
    output logic [DATA_WIDTH-1:0] msg_data,
    output logic                  msg_last,
    output logic [7:0]            msg_id,
    output logic                  err
);

    mbx_state_t            r_state;
    mbx_state_t            w_state_nxt;
    logic [13:0]           r_index;
    logic [14:0]           r_size;
    logic [7:0]            r_msg_id;
    logic [DATA_WIDTH-1:0] r_msg_data;
    logic                  r_err;
    logic                  w_err_set;

    logic                  w_resp_err;
    logic [14:0]           w_rd_size;
    logic [7:0]            w_rd_id;
    logic                  w_last;
    logic [ADDR_WIDTH-1:0] w_pay_addr;
    mbox_ctrl_t            w_ack;

    assign w_resp_err = (hresp == HRESP_ERROR);
    assign w_rd_size  = hrdata[22:8];
    assign w_rd_id    = hrdata[7:0];
    // Only evaluated in PUSH, where size is at least 1.
    assign w_last     = ((r_size - 15'd1) == {1'b0, r_index});
    // Index tops out at 8191 here, so the offset never passes 0x7FFC.
    assign w_pay_addr = BASE_ADDR + ADDR_WIDTH'(PAYLOAD_OFFSET)
                      + ADDR_WIDTH'({r_index, 2'b00});
    assign w_ack      = ack_word(r_size, r_msg_id);

    assign hsize    = HSIZE_WORD;
    assign hburst   = HBURST_SINGLE;
    assign hprot    = HPROT_DEFAULT;
    assign msg_data = r_msg_data;
    assign msg_id   = r_msg_id;
    assign err      = r_err;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_err_set   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable && mailbox_intr) begin
                    w_state_nxt = ST_CTRL_A;
                end
            end
            ST_CTRL_A: begin
                if (hready) begin
                    w_state_nxt = ST_CTRL_D;
                end
            end
            ST_CTRL_D: begin
                if (hready) begin
                    if (w_resp_err || (w_rd_size > MAX_MSG_WORDS)) begin
                        w_err_set   = 1'b1;
                        w_state_nxt = ST_ACK_A;
                    end else if (w_rd_size == 15'd0) begin
                        w_state_nxt = ST_ACK_A;
                    end else begin
                        w_state_nxt = ST_DATA_A;
                    end
                end
            end
            ST_DATA_A: begin
                if (hready) begin
                    w_state_nxt = ST_DATA_D;
                end
            end
            ST_DATA_D: begin
                if (hready) begin
                    if (w_resp_err) begin
                        w_err_set   = 1'b1;
                        w_state_nxt = ST_ACK_A;
                    end else begin
                        w_state_nxt = ST_PUSH;
                    end
                end
            end
            ST_PUSH: begin
                if (msg_ready) begin
                    w_state_nxt = w_last ? ST_ACK_A : ST_DATA_A;
                end
            end
            ST_ACK_A: begin
                if (hready) begin
                    w_state_nxt = ST_ACK_D;
                end
            end
            ST_ACK_D: begin
                if (hready) begin
                    w_err_set   = w_resp_err;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!mailbox_intr) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Address-phase signals are pure functions of the state, so they hold
    // steady for as long as the slave stretches the address phase.
    always_comb begin
        htrans    = HTRANS_IDLE;
        haddr     = '0;
        hwrite    = 1'b0;
        hwdata    = '0;
        msg_valid = 1'b0;
        msg_last  = 1'b0;
        case (r_state)
            ST_CTRL_A: begin
                htrans = HTRANS_NONSEQ;
                haddr  = BASE_ADDR;
            end
            ST_DATA_A: begin
                htrans = HTRANS_NONSEQ;
                haddr  = w_pay_addr;
            end
            ST_ACK_A: begin
                htrans = HTRANS_NONSEQ;
                haddr  = BASE_ADDR;
                hwrite = 1'b1;
            end
            ST_ACK_D: begin
                hwdata = DATA_WIDTH'(w_ack);
            end
            ST_PUSH: begin
                msg_valid = 1'b1;
                msg_last  = w_last;
            end
            default: ;
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_index    <= '0;
            r_size     <= '0;
            r_msg_id   <= '0;
            r_msg_data <= '0;
            r_err      <= 1'b0;
        end else begin
            r_err <= w_err_set;
            case (r_state)
                ST_CTRL_D: begin
                    if (hready) begin
                        r_size   <= w_rd_size;
                        r_msg_id <= w_rd_id;
                        r_index  <= '0;
                    end
                end
                ST_DATA_D: begin
                    if (hready && !w_resp_err) begin
                        r_msg_data <= hrdata;
                    end
                end
                ST_PUSH: begin
                    if (msg_ready) begin
                        r_index <= r_index + 14'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_mailbox_reader.sv
module tb_ahb_mailbox_reader;
    import ahb_enum::*;

    logic        hclk = 1'b0;
    logic        hresetn = 1'b0;
    logic        enable = 1'b0;
    logic        mailbox_intr = 1'b0;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic [31:0] hrdata = 32'h0;
    logic        hready = 1'b1;
    logic [1:0]  hresp = 2'b00;
    logic        msg_valid;
    logic        msg_ready = 1'b1;
    logic [31:0] msg_data;
    logic        msg_last;
    logic [7:0]  msg_id;
    logic        err;

    ahb_mailbox_reader dut (
        .hclk(hclk), .hresetn(hresetn), .enable(enable), .mailbox_intr(mailbox_intr),
        .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
        .hburst(hburst), .hprot(hprot), .hwdata(hwdata), .hrdata(hrdata),
        .hready(hready), .hresp(hresp), .msg_valid(msg_valid), .msg_ready(msg_ready),
        .msg_data(msg_data), .msg_last(msg_last), .msg_id(msg_id), .err(err)
    );

    always #5 hclk = ~hclk;

    // configuration written by the directed sequence, read by the models
    logic [31:0] mem_ctrl = 32'h0;
    logic [31:0] mem_pay [0:15];
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    logic [31:0] dwait_addr = 32'hFFFF_FFFF;
    int          dwait_cnt = 0;
    int          astall_at = -1;
    int          astall_len = 0;
    int          stall_at = -1;
    int          stall_len = 0;

    // model state and monitor counters, written only by the models
    int acc_count = 0, ctrl_rd = 0, pay_rd = 0, wr_count = 0;
    int astall_total = 0, astall_bad = 0, dwait_total = 0;
    int beats = 0, valid_cycles = 0, stall_total = 0, stall_changed = 0, stall_xfer = 0;
    int err_cycles = 0, astall_cur = 0, stall_cur = 0, dp_wait = 0, pidx = 0;
    logic [31:0] wr_addr = 32'h0, wr_data = 32'h0;
    logic [31:0] ast_addr = 32'h0, stall_ref = 32'h0;
    logic [1:0]  ast_trans = 2'b0;
    logic        ast_wr = 1'b0;
    bit          dp_next = 0, dp_active = 0, dp_write = 0, dp_err = 0, dp_errph = 0, dp_write_n = 0;
    logic [31:0] dp_addr = 32'h0, dp_addr_n = 32'h0;
    logic [31:0] beat_data [0:63];
    logic        beat_last [0:63];
    logic [7:0]  beat_id   [0:63];

    int n_tests = 0;
    int n_fail = 0;

    function automatic logic [31:0] pay(input int k);
        return 32'h5A00_1000 + 32'(k) * 32'h0011_0011;
    endfunction

    // AHB slave and sink models, updated on the falling edge
    always @(negedge hclk) begin
        if (!hresetn) begin
            dp_next = 0; dp_active = 0; astall_cur = 0; stall_cur = 0;
            hready = 1'b1; hresp = HRESP_OKAY; hrdata = 32'h0; msg_ready = 1'b1;
        end else begin
            if (dp_next) begin
                dp_next = 0; dp_active = 1; dp_addr = dp_addr_n; dp_write = dp_write_n;
                dp_err = (dp_addr_n == err_addr); dp_errph = 0;
                dp_wait = (dp_addr_n == dwait_addr) ? dwait_cnt : 0;
            end
            if (dp_active) begin
                if (dp_wait > 0) begin
                    hready = 1'b0; hresp = HRESP_OKAY; dp_wait--; dwait_total++;
                end else if (dp_err && !dp_errph) begin
                    hready = 1'b0; hresp = HRESP_ERROR; dp_errph = 1;
                end else begin
                    hready = 1'b1;
                    hresp = dp_err ? HRESP_ERROR : HRESP_OKAY;
                    if (dp_write) begin
                        wr_count++; wr_addr = dp_addr; wr_data = hwdata; hrdata = 32'h0;
                    end else if (dp_addr == 32'h0) begin
                        ctrl_rd++; hrdata = mem_ctrl;
                    end else begin
                        pay_rd++;
                        pidx = int'((dp_addr - 32'h8000) >> 2);
                        hrdata = (pidx >= 0 && pidx < 16) ? mem_pay[pidx] : 32'h0;
                    end
                    dp_active = 0;
                end
            end else begin
                hresp = HRESP_OKAY;
                hrdata = 32'hBAD0_BAD0;
                hready = 1'b1;
                if (htrans == HTRANS_NONSEQ) begin
                    if (acc_count == astall_at && astall_cur < astall_len) begin
                        if (astall_cur == 0) begin
                            ast_addr = haddr; ast_trans = htrans; ast_wr = hwrite;
                        end else if (haddr !== ast_addr || htrans !== ast_trans || hwrite !== ast_wr) begin
                            astall_bad++;
                        end
                        astall_cur++; astall_total++; hready = 1'b0;
                    end else begin
                        if (astall_cur > 0 && (haddr !== ast_addr || hwrite !== ast_wr)) astall_bad++;
                        astall_cur = 0;
                        acc_count++; dp_next = 1; dp_addr_n = haddr; dp_write_n = hwrite;
                    end
                end
            end
            msg_ready = 1'b1;
            if (msg_valid) begin
                valid_cycles++;
                if (beats == stall_at && stall_cur < stall_len) begin
                    if (stall_cur == 0) stall_ref = msg_data;
                    else if (msg_data !== stall_ref) stall_changed++;
                    if (htrans != HTRANS_IDLE) stall_xfer++;
                    stall_cur++; stall_total++; msg_ready = 1'b0;
                end else begin
                    if (stall_cur > 0 && msg_data !== stall_ref) stall_changed++;
                    if (beats < 64) begin
                        beat_data[beats] = msg_data; beat_last[beats] = msg_last; beat_id[beats] = msg_id;
                    end
                    beats++; stall_cur = 0;
                end
            end
            if (err) err_cycles++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge hclk);
        #2;
    endtask

    task automatic wait_writes(input int target, input string tag);
        for (int i = 0; i < 600 && wr_count < target; i++) cyc(1);
        check(tag, 64'(wr_count >= target), 64'd1);
    endtask

    task automatic wait_beats(input int target, input string tag);
        for (int i = 0; i < 300 && beats < target; i++) cyc(1);
        check(tag, 64'(beats >= target), 64'd1);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_htrans"}, 64'(htrans), 64'd0);
        check({pfx, "_haddr"}, 64'(haddr), 64'd0);
        check({pfx, "_hwrite"}, 64'(hwrite), 64'd0);
        check({pfx, "_hwdata"}, 64'(hwdata), 64'd0);
        check({pfx, "_msg_valid"}, 64'(msg_valid), 64'd0);
        check({pfx, "_msg_last"}, 64'(msg_last), 64'd0);
        check({pfx, "_msg_data"}, 64'(msg_data), 64'd0);
        check({pfx, "_msg_id"}, 64'(msg_id), 64'd0);
        check({pfx, "_err"}, 64'(err), 64'd0);
    endtask

    int b_beats, b_wr, b_ctrl, b_pay, b_err, b_vc, b_st, b_sc, b_sx, b_ast, b_asb, b_dw;

    task automatic snap();
        b_beats = beats; b_wr = wr_count; b_ctrl = ctrl_rd; b_pay = pay_rd; b_err = err_cycles;
        b_vc = valid_cycles; b_st = stall_total; b_sc = stall_changed; b_sx = stall_xfer;
        b_ast = astall_total; b_asb = astall_bad; b_dw = dwait_total;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem_pay[i] = pay(i);

        // reset values and constant outputs
        cyc(3);
        check_reset_outputs("rst");
        check("hsize", 64'(hsize), 64'h2);
        check("hburst", 64'(hburst), 64'h0);
        check("hprot", 64'(hprot), 64'h3);
        hresetn = 1'b1;

        // interrupt without enable is ignored
        mailbox_intr = 1'b1;
        cyc(6);
        check("no_enable_no_xfer", 64'(acc_count), 64'd0);

        // basic 3-word message
        mem_ctrl = 32'h8000_0305;
        snap();
        enable = 1'b1;
        wait_writes(b_wr + 1, "t1_ack_seen");
        cyc(6);
        check("t1_beats", 64'(beats - b_beats), 64'd3);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("t1_data%0d", k), 64'(beat_data[b_beats + k]), 64'(pay(k)));
            check($sformatf("t1_id%0d", k), 64'(beat_id[b_beats + k]), 64'h05);
        end
        check("t1_last", 64'({beat_last[b_beats + 2], beat_last[b_beats + 1], beat_last[b_beats]}), 64'b100);
        check("t1_ack_addr", 64'(wr_addr), 64'h0);
        check("t1_ack_data", 64'(wr_data), 64'h4000_0305);
        check("t1_pay_reads", 64'(pay_rd - b_pay), 64'd3);
        check("t1_no_reservice", 64'(ctrl_rd - b_ctrl), 64'd1);
        check("t1_no_err", 64'(err_cycles - b_err), 64'd0);
        mailbox_intr = 1'b0;
        cyc(3);

        // sink stalls 5 cycles on beat 2, enable dropped mid-message
        snap();
        stall_at = b_beats + 1;
        stall_len = 5;
        mailbox_intr = 1'b1;
        wait_beats(b_beats + 1, "t2_first_beat");
        enable = 1'b0;
        wait_writes(b_wr + 1, "t2_ack_seen");
        cyc(2);
        check("t2_beats", 64'(beats - b_beats), 64'd3);
        check("t2_data1", 64'(beat_data[b_beats + 1]), 64'(pay(1)));
        check("t2_data2", 64'(beat_data[b_beats + 2]), 64'(pay(2)));
        check("t2_stall_cycles", 64'(stall_total - b_st), 64'd5);
        check("t2_data_held", 64'(stall_changed - b_sc), 64'd0);
        check("t2_no_xfer_in_stall", 64'(stall_xfer - b_sx), 64'd0);
        check("t2_valid_cycles", 64'(valid_cycles - b_vc), 64'd8);
        check("t2_ack_data", 64'(wr_data), 64'h4000_0305);
        stall_at = -1;
        mailbox_intr = 1'b0;
        enable = 1'b1;
        cyc(3);

        // empty message
        mem_ctrl = 32'h8000_0007;
        snap();
        mailbox_intr = 1'b1;
        wait_writes(b_wr + 1, "t3_ack_seen");
        cyc(2);
        check("t3_pay_reads", 64'(pay_rd - b_pay), 64'd0);
        check("t3_valid_cycles", 64'(valid_cycles - b_vc), 64'd0);
        check("t3_ack_data", 64'(wr_data), 64'h4000_0007);
        mailbox_intr = 1'b0;
        cyc(3);

        // address-phase stall on control read, data-phase wait on payload word 1
        mem_ctrl = 32'h8000_0209;
        snap();
        astall_at = acc_count;
        astall_len = 4;
        dwait_addr = 32'h0000_8004;
        dwait_cnt = 4;
        mailbox_intr = 1'b1;
        wait_writes(b_wr + 1, "t4_ack_seen");
        cyc(2);
        check("t4_astall_cycles", 64'(astall_total - b_ast), 64'd4);
        check("t4_addr_stable", 64'(astall_bad - b_asb), 64'd0);
        check("t4_dwait_cycles", 64'(dwait_total - b_dw), 64'd4);
        check("t4_beats", 64'(beats - b_beats), 64'd2);
        check("t4_data0", 64'(beat_data[b_beats]), 64'(pay(0)));
        check("t4_data1", 64'(beat_data[b_beats + 1]), 64'(pay(1)));
        check("t4_ack_data", 64'(wr_data), 64'h4000_0209);
        astall_at = -1;
        dwait_addr = 32'hFFFF_FFFF;
        mailbox_intr = 1'b0;
        cyc(3);

        // ERROR response on payload word 2 of 4
        mem_ctrl = 32'h8000_040B;
        snap();
        err_addr = 32'h0000_8004;
        mailbox_intr = 1'b1;
        wait_writes(b_wr + 1, "t5_ack_seen");
        cyc(4);
        check("t5_beats", 64'(beats - b_beats), 64'd1);
        check("t5_data0", 64'(beat_data[b_beats]), 64'(pay(0)));
        check("t5_err_pulse", 64'(err_cycles - b_err), 64'd1);
        check("t5_pay_reads", 64'(pay_rd - b_pay), 64'd2);
        check("t5_ack_data", 64'(wr_data), 64'h4000_040B);
        check("t5_done_holds", 64'(ctrl_rd - b_ctrl), 64'd1);
        err_addr = 32'hFFFF_FFFF;
        mailbox_intr = 1'b0;
        cyc(3);

        // oversize message (8193 words)
        mem_ctrl = 32'h8020_010C;
        snap();
        mailbox_intr = 1'b1;
        wait_writes(b_wr + 1, "t6_ack_seen");
        cyc(2);
        check("t6_err_pulse", 64'(err_cycles - b_err), 64'd1);
        check("t6_pay_reads", 64'(pay_rd - b_pay), 64'd0);
        check("t6_valid_cycles", 64'(valid_cycles - b_vc), 64'd0);
        check("t6_ack_data", 64'(wr_data), 64'h4020_010C);
        mailbox_intr = 1'b0;
        cyc(3);

        // reset while the payload data phase is stretched
        mem_ctrl = 32'h8000_0305;
        snap();
        dwait_addr = 32'h0000_8004;
        dwait_cnt = 20;
        mailbox_intr = 1'b1;
        wait_beats(b_beats + 1, "t7_first_beat");
        cyc(3);
        hresetn = 1'b0;
        #1;
        check_reset_outputs("t7_rst");
        dwait_addr = 32'hFFFF_FFFF;
        cyc(2);
        snap();
        hresetn = 1'b1;
        wait_writes(b_wr + 1, "t7_ack_seen");
        cyc(2);
        check("t7_ctrl_reads", 64'(ctrl_rd - b_ctrl), 64'd1);
        check("t7_beats", 64'(beats - b_beats), 64'd3);
        check("t7_data0", 64'(beat_data[b_beats]), 64'(pay(0)));
        check("t7_data2", 64'(beat_data[b_beats + 2]), 64'(pay(2)));
        check("t7_ack_data", 64'(wr_data), 64'h4000_0305);
        mailbox_intr = 1'b0;
        cyc(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
